ate_ctrl: RTL and testbench

Frame sequencer for the adaptive-threshold engine (`ate`). On `start`, it reads a 48x32 8-bit image from a raster-ordered pixel memory and re-orders it into 8x8 block order for the engine. It captures the engine's binarised output and per-block threshold, and writes them back in raster order to a 1-bit result memory and a 24-entry threshold table. It owns the engine's reset, pixel pacing, pipeline flush and edge-block masking, so the engine stays a free-running datapath.

---
 rtl/ate_pkg.sv | 37 +++
 rtl/ate_blk_addr.sv | 60 ++++++
 rtl/ate_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ate_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ate_pkg                                                         |
// | Purpose  : Shared geometry, latency constants and types for the adaptive-  |
// |            threshold engine frame sequencer.                               |
// | Contents : IMG_W/IMG_H/BLK/N_PIX/N_BLK image geometry, BIN_LAT engine      |
// |            latency, ate_ctrl_state_t sequencer states, blk_pos_t position. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ate_pkg;

    localparam int IMG_W   = 48;
    localparam int IMG_H   = 32;
    localparam int BLK     = 8;
    localparam int N_PIX   = IMG_W * IMG_H;
    localparam int N_BLK   = (IMG_W / BLK) * (IMG_H / BLK);
    localparam int BIN_LAT = 65;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } ate_ctrl_state_t;

    // Position of a pixel in block order: block column/row, then row and
    // column inside the 8x8 block.
    typedef struct packed {
        logic [1:0] by;
        logic [2:0] bx;
        logic [2:0] r;
        logic [2:0] c;
    } blk_pos_t;

endpackage
`default_nettype wire

// File: rtl/ate_blk_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ate_blk_addr                                                    |
// | Purpose  : Walks a frame in 8x8 block order and yields the raster address  |
// |            of the current pixel. Block coordinates are kept as counters so |
// |            no divider is needed.                                           |
// | Ports    : clk, reset (async, active-low)                                  |
// |            i_clr  - return to pixel 0                                      |
// |            i_en   - advance one pixel                                      |
// |            o_pos  - current block-order position                           |
// |            o_addr - raster address (by*8+r)*IMG_W + bx*8 + c               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ate_blk_addr
    import ate_pkg::*;
#(
    parameter int BLK_W = 6,
    parameter int BLK_H = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_en,
    output blk_pos_t    o_pos,
    output logic [10:0] o_addr
);

    localparam logic [2:0] c_BX_LAST = 3'(BLK_W - 1);
    localparam logic [1:0] c_BY_LAST = 2'(BLK_H - 1);

    blk_pos_t r_pos;

    // c and r are 3 bits wide, so they wrap at the 8-pixel block edge for free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos <= '0;
        end else if (i_clr) begin
            r_pos <= '0;
        end else if (i_en) begin
            r_pos.c <= r_pos.c + 3'd1;
            if (r_pos.c == 3'd7) begin
                r_pos.r <= r_pos.r + 3'd1;
                if (r_pos.r == 3'd7) begin
                    if (r_pos.bx == c_BX_LAST) begin
                        r_pos.bx <= 3'd0;
                        r_pos.by <= (r_pos.by == c_BY_LAST) ? 2'd0 : r_pos.by + 2'd1;
                    end else begin
                        r_pos.bx <= r_pos.bx + 3'd1;
                    end
                end
            end
        end
    end

    assign o_pos  = r_pos;
    // {by,r} is the image row and {bx,c} the image column.
    assign o_addr = 11'({r_pos.by, r_pos.r}) * 11'(IMG_W) + 11'({r_pos.bx, r_pos.c});

endmodule
`default_nettype wire

// File: rtl/ate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ate_ctrl                                                        |
// | Purpose  : Frame sequencer for the adaptive-threshold engine. Reads a      |
// |            raster image in 8x8 block order, streams it to the engine,      |
// |            flushes the engine pipeline and writes the binarised result and |
// |            per-block thresholds back in raster order, masking edge blocks. |
// | Ports    : clk, reset (async, active-low), start, busy, done              |
// |            rd_addr/rd_en/rd_data         - pixel memory (1-cycle latency)  |
// |            eng_reset/eng_pix/eng_bin/eng_thr - engine interface            |
// |            wr_en/wr_addr/wr_data         - 1-bit result memory             |
// |            thr_we/thr_addr/thr_data      - per-block threshold table       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ate_ctrl
    import ate_pkg::*;
#(
    parameter int BLK_W   = 6,
    parameter int BLK_H   = 4,
    parameter int BIN_LAT = ate_pkg::BIN_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [10:0] rd_addr,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    output logic        eng_reset,
    output logic [7:0]  eng_pix,
    input  logic        eng_bin,
    input  logic [7:0]  eng_thr,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic        wr_data,
    output logic        thr_we,
    output logic [4:0]  thr_addr,
    output logic [7:0]  thr_data
);

    // r_tick counts STREAM cycles 0..N_PIX-1 and continues through FLUSH.
    localparam logic [10:0] c_STREAM_LAST = 11'(N_PIX - 1);
    localparam logic [10:0] c_RUN_LAST    = 11'(N_PIX + BIN_LAT - 1);
    localparam logic [10:0] c_WR_FIRST    = 11'(BIN_LAT);
    localparam logic [2:0]  c_BX_LAST     = 3'(BLK_W - 1);

    ate_ctrl_state_t r_state;
    ate_ctrl_state_t w_state_nxt;
    logic [10:0]     r_tick;
    logic            w_run;
    logic            w_clr;
    logic            w_edge;
    logic            w_blk_first;
    blk_pos_t        w_rd_pos;
    blk_pos_t        w_wr_pos;

    assign w_run = (r_state == ST_STREAM) || (r_state == ST_FLUSH);
    assign w_clr = (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tick  <= 11'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_run ? r_tick + 11'd1 : 11'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        rd_en       = 1'b0;
        eng_reset   = 1'b0;
        eng_pix     = 8'd0;
        wr_en       = 1'b0;
        wr_data     = 1'b0;
        thr_we      = 1'b0;
        thr_data    = 8'd0;
        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                eng_reset = 1'b1;
                if (start) begin
                    w_state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                eng_reset   = 1'b1;
                rd_en       = 1'b1;
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                eng_pix = rd_data;
                // The read counter wraps back to pixel 0 once the last pixel
                // has been requested, which marks the final STREAM cycle.
                rd_en   = (w_rd_pos != '0);
                if (r_tick == c_STREAM_LAST) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_tick == c_RUN_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                eng_reset   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                eng_reset   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Engine output for pixel m appears BIN_LAT cycles after it was fed.
        if (w_run && (r_tick >= c_WR_FIRST)) begin
            wr_en   = 1'b1;
            wr_data = eng_bin & ~w_edge;
            thr_we  = w_blk_first;
            if (w_blk_first && !w_edge) begin
                thr_data = eng_thr;
            end
        end
    end

    ate_blk_addr #(
        .BLK_W (BLK_W),
        .BLK_H (BLK_H)
    ) u_rd_addr (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (rd_en),
        .o_pos  (w_rd_pos),
        .o_addr (rd_addr)
    );

    ate_blk_addr #(
        .BLK_W (BLK_W),
        .BLK_H (BLK_H)
    ) u_wr_addr (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (wr_en),
        .o_pos  (w_wr_pos),
        .o_addr (wr_addr)
    );

    // Left and right block columns see a truncated neighbourhood in the
    // engine, so their results are forced to 0.
    assign w_edge      = (w_wr_pos.bx == 3'd0) || (w_wr_pos.bx == c_BX_LAST);
    assign w_blk_first = (w_wr_pos.r == 3'd0) && (w_wr_pos.c == 3'd0);
    assign thr_addr    = 5'(w_wr_pos.by) * 5'(BLK_W) + 5'(w_wr_pos.bx);

endmodule
`default_nettype wire

// File: tb/tb_ate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ate_ctrl                                                     |
// | Purpose  : Directed self-checking bench for ate_ctrl with a pixel memory,  |
// |            a behavioural engine stand-in (block mid-range threshold,       |
// |            65-cycle latency) and a result/threshold recorder.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ate_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, rd_en, eng_reset, eng_bin, wr_en, wr_data, thr_we;
    logic [10:0] rd_addr, wr_addr;
    logic [7:0]  rd_data, eng_pix, eng_thr, thr_data;
    logic [4:0]  thr_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ate_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .eng_reset (eng_reset),
        .eng_pix   (eng_pix),
        .eng_bin   (eng_bin),
        .eng_thr   (eng_thr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .thr_we    (thr_we),
        .thr_addr  (thr_addr),
        .thr_data  (thr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory, one-cycle read latency.
    logic [7:0] mem [0:1535];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Engine stand-in: records samples while out of reset and, 65 cycles
    // after sample j, presents bit/threshold of j using its block's mid-range.
    logic [7:0] hist [0:2047];
    int ecnt = 0;
    always @(posedge clk) begin
        if (eng_reset) ecnt <= 0;
        else begin
            if (ecnt < 2048) hist[ecnt] <= eng_pix;
            ecnt <= ecnt + 1;
        end
    end
    always @(negedge clk) begin : eng_model
        int j, b, mn, mx;
        eng_bin = 1'b0;
        eng_thr = 8'd0;
        j = ecnt - 65;
        if (!eng_reset && j >= 0 && j < 1536) begin
            b = (j / 64) * 64;
            mn = 255; mx = 0;
            for (int k = 0; k < 64; k++) begin
                if (int'(hist[b+k]) < mn) mn = int'(hist[b+k]);
                if (int'(hist[b+k]) > mx) mx = int'(hist[b+k]);
            end
            eng_thr = 8'((mn + mx) / 2);
            eng_bin = (hist[j] >= eng_thr);
        end
    end

    // Recorder, sampled 1 time unit after the falling edge.
    logic       res [0:1535];
    int         wcnt [0:1535];
    int         rd_log [0:1535];
    int         wr_log [0:1535];
    logic [7:0] thr_tab [0:23];
    int thr_cnt, wr_total, rd_total, done_cnt, done_cyc, busy_cnt;
    int first_rd, first_wr, last_wr;
    logic done_eng_rst;

    always @(negedge clk) begin
        #1;
        if (busy === 1'b1) busy_cnt++;
        if (rd_en === 1'b1) begin
            if (rd_total == 0) first_rd = cyc;
            if (rd_total < 1536) rd_log[rd_total] = int'(rd_addr);
            rd_total++;
        end
        if (wr_en === 1'b1) begin
            if (wr_total == 0) first_wr = cyc;
            last_wr = cyc;
            if (wr_total < 1536) wr_log[wr_total] = int'(wr_addr);
            wr_total++;
            if (wr_addr < 11'd1536) begin
                res[wr_addr] = wr_data;
                wcnt[wr_addr]++;
            end
        end
        if (thr_we === 1'b1) begin
            thr_cnt++;
            if (thr_addr < 5'd24) thr_tab[thr_addr] = thr_data;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_eng_rst = eng_reset;
        end
    end

    task automatic clear_rec();
        for (int a = 0; a < 1536; a++) begin
            res[a] = 1'bx; wcnt[a] = 0; rd_log[a] = -1; wr_log[a] = -1;
        end
        for (int b = 0; b < 24; b++) thr_tab[b] = 8'hxx;
        thr_cnt = 0; wr_total = 0; rd_total = 0; done_cnt = 0; done_cyc = -1;
        busy_cnt = 0; first_rd = -1; first_wr = -1; last_wr = -1; done_eng_rst = 1'b0;
    endtask

    // Pulses start, optionally re-pulses it extra_at cycles later, and returns
    // in the DONE cycle (or after a bounded wait).
    task automatic run_frame(input int extra_at, output int s);
        bit ok;
        @(negedge clk); start = 1'b1; s = cyc;
        @(negedge clk); start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = ((cyc - s) == extra_at);
            #2;
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL frame_timeout got=no_done want=done_within_2000"); end
    endtask

    // Reference model helpers, all derived from the memory image.
    function automatic int blk_order_addr(input int n);
        int b = n / 64;
        return ((b / 6) * 8 + (n / 8) % 8) * 48 + (b % 6) * 8 + n % 8;
    endfunction

    function automatic logic [7:0] exp_thr(input int blk);
        int by = blk / 6, bx = blk % 6, mn = 255, mx = 0, v;
        if (bx == 0 || bx == 5) return 8'd0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                v = int'(mem[(by*8 + r)*48 + bx*8 + c]);
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
        return 8'((mn + mx) / 2);
    endfunction

    function automatic logic exp_bit(input int a);
        int bx = (a % 48) / 8, by = (a / 48) / 8;
        if (bx == 0 || bx == 5) return 1'b0;
        return (mem[a] >= exp_thr(by*6 + bx));
    endfunction

    function automatic int bit_errs();
        int n = 0;
        for (int a = 0; a < 1536; a++) if (res[a] !== exp_bit(a) || wcnt[a] != 1) n++;
        return n;
    endfunction

    function automatic int thr_errs();
        int n = 0;
        for (int b = 0; b < 24; b++) if (thr_tab[b] !== exp_thr(b)) n++;
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({busy, done, rd_en, wr_en, thr_we} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=00000", {busy, done, rd_en, wr_en, thr_we});
        end
        total++;
        if (eng_reset !== 1'b1) begin bad++; $display("FAIL reset_eng_reset got=%b want=1", eng_reset); end
        total++;
        if (eng_pix !== 8'd0) begin bad++; $display("FAIL reset_eng_pix got=%0d want=0", eng_pix); end
        total++;
        if ({rd_addr, wr_addr, thr_addr} !== 27'd0) begin
            bad++; $display("FAIL reset_addrs got=%0d/%0d/%0d want=0/0/0", rd_addr, wr_addr, thr_addr);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_uniform();
        int s, n;
        for (int a = 0; a < 1536; a++) mem[a] = 8'd100;
        clear_rec();
        run_frame(-1, s);
        total++;
        if (done_cyc - s != 1603) begin bad++; $display("FAIL uniform_done_cycle got=%0d want=1603", done_cyc - s); end
        total++;
        if (busy_cnt != 1603) begin bad++; $display("FAIL uniform_busy_cycles got=%0d want=1603", busy_cnt); end
        total++;
        if (first_rd - s != 1) begin bad++; $display("FAIL uniform_first_read got=%0d want=1", first_rd - s); end
        total++;
        if (first_wr - s != 67) begin bad++; $display("FAIL uniform_first_write got=%0d want=67", first_wr - s); end
        total++;
        if (last_wr - s != 1602) begin bad++; $display("FAIL uniform_last_write got=%0d want=1602", last_wr - s); end
        total++;
        if (rd_total != 1536 || wr_total != 1536 || thr_cnt != 24 || done_cnt != 1) begin
            bad++; $display("FAIL uniform_counts got=rd%0d/wr%0d/thr%0d/done%0d want=1536/1536/24/1",
                            rd_total, wr_total, thr_cnt, done_cnt);
        end
        // Interior columns x=8..39 binarise to 1 (100 >= 100), edge columns to 0.
        n = 0;
        for (int a = 0; a < 1536; a++)
            if (res[a] !== ((a % 48) >= 8 && (a % 48) < 40) || wcnt[a] != 1) n++;
        total++;
        if (n != 0) begin bad++; $display("FAIL uniform_bits got=%0d_wrong want=0_wrong", n); end
        for (int b = 0; b < 24; b++) begin
            total++;
            if (thr_tab[b] !== (((b % 6) == 0 || (b % 6) == 5) ? 8'd0 : 8'd100)) begin
                bad++; $display("FAIL uniform_thr[%0d] got=%0d want=%0d", b, thr_tab[b],
                                ((b % 6) == 0 || (b % 6) == 5) ? 0 : 100);
            end
        end
    endtask

    task automatic test_addr_order();
        int s, n;
        for (int a = 0; a < 1536; a++) mem[a] = 8'(a);
        clear_rec();
        run_frame(-1, s);
        n = 0;
        for (int i = 0; i < 8; i++) if (rd_log[i] != i) n++;
        total++;
        if (n != 0) begin bad++; $display("FAIL order_first_row got=%0d_wrong want=0_wrong", n); end
        total++;
        if (rd_log[8] != 48) begin bad++; $display("FAIL order_rd8 got=%0d want=48", rd_log[8]); end
        total++;
        if (rd_log[64] != 8) begin bad++; $display("FAIL order_blk1_start got=%0d want=8", rd_log[64]); end
        total++;
        if (rd_log[384] != 384) begin bad++; $display("FAIL order_blk6_start got=%0d want=384", rd_log[384]); end
        total++;
        if (rd_log[1535] != 1535) begin bad++; $display("FAIL order_last got=%0d want=1535", rd_log[1535]); end
        n = 0;
        for (int i = 0; i < 1536; i++)
            if (rd_log[i] != blk_order_addr(i) || wr_log[i] != blk_order_addr(i)) n++;
        total++;
        if (n != 0) begin bad++; $display("FAIL order_sequence got=%0d_wrong want=0_wrong", n); end
        n = bit_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL order_bits got=%0d_wrong want=0_wrong", n); end
        n = thr_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL order_thr got=%0d_wrong want=0_wrong", n); end
    endtask

    task automatic test_block_thr();
        int s, n;
        for (int a = 0; a < 1536; a++) mem[a] = 8'd0;
        // Block (bx=1,by=0): k = r*8+c carries 10+3k, last pixel 200 -> mid-range 105.
        for (int k = 0; k < 64; k++) mem[(k / 8)*48 + 8 + k % 8] = (k == 63) ? 8'd200 : 8'(10 + 3*k);
        clear_rec();
        run_frame(-1, s);
        total++;
        if (thr_tab[1] !== 8'd105) begin bad++; $display("FAIL blk_thr1 got=%0d want=105", thr_tab[1]); end
        total++;
        if (thr_tab[0] !== 8'd0) begin bad++; $display("FAIL blk_thr0 got=%0d want=0", thr_tab[0]); end
        total++;
        if (res[3*48 + 15] !== 1'b0) begin bad++; $display("FAIL blk_bit_103 got=%b want=0", res[3*48 + 15]); end
        total++;
        if (res[4*48 + 8] !== 1'b1) begin bad++; $display("FAIL blk_bit_106 got=%b want=1", res[4*48 + 8]); end
        total++;
        if (res[8] !== 1'b0 || res[7*48 + 15] !== 1'b1) begin
            bad++; $display("FAIL blk_bit_ends got=%b%b want=01", res[8], res[7*48 + 15]);
        end
        n = bit_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL blk_bits got=%0d_wrong want=0_wrong", n); end
    endtask

    task automatic test_start_busy();
        int s, n;
        for (int a = 0; a < 1536; a++) mem[a] = 8'(a * 7);
        clear_rec();
        run_frame(500, s);
        repeat (3) @(negedge clk);
        #2;
        total++;
        if (done_cnt != 1 || wr_total != 1536 || thr_cnt != 24) begin
            bad++; $display("FAIL busy_counts got=done%0d/wr%0d/thr%0d want=1/1536/24", done_cnt, wr_total, thr_cnt);
        end
        total++;
        if (done_cyc - s != 1603) begin bad++; $display("FAIL busy_done_cycle got=%0d want=1603", done_cyc - s); end
        n = bit_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL busy_bits got=%0d_wrong want=0_wrong", n); end
    endtask

    task automatic test_reset_mid();
        int s, n;
        for (int a = 0; a < 1536; a++) mem[a] = 8'(a) ^ 8'h5A;
        clear_rec();
        @(negedge clk); start = 1'b1; s = cyc;
        @(negedge clk); start = 1'b0;
        repeat (799) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        total++;
        if ({busy, done, rd_en, wr_en, thr_we} !== 5'b0 || eng_reset !== 1'b1) begin
            bad++; $display("FAIL midreset_idle got=%b/%b want=00000/1", {busy, done, rd_en, wr_en, thr_we}, eng_reset);
        end
        @(negedge clk); reset = 1'b1;
        clear_rec();
        run_frame(-1, s);
        total++;
        if (done_cyc - s != 1603 || wr_total != 1536) begin
            bad++; $display("FAIL midreset_frame got=%0d/%0d want=1603/1536", done_cyc - s, wr_total);
        end
        n = bit_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL midreset_bits got=%0d_wrong want=0_wrong", n); end
        n = thr_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL midreset_thr got=%0d_wrong want=0_wrong", n); end
    endtask

    task automatic test_back_to_back();
        int s1, s2, d1, n;
        for (int a = 0; a < 1536; a++) mem[a] = 8'd100;
        clear_rec();
        run_frame(-1, s1);
        d1 = done_cyc;
        total++;
        if (done_eng_rst !== 1'b1) begin bad++; $display("FAIL b2b_done_eng_reset got=%b want=1", done_eng_rst); end
        n = bit_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL b2b_frame1_bits got=%0d_wrong want=0_wrong", n); end
        for (int a = 0; a < 1536; a++) mem[a] = 8'(a * 13 + 5);
        clear_rec();
        run_frame(-1, s2);
        total++;
        if (done_cyc - d1 != 1604) begin bad++; $display("FAIL b2b_period got=%0d want=1604", done_cyc - d1); end
        n = bit_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL b2b_frame2_bits got=%0d_wrong want=0_wrong", n); end
        n = thr_errs();
        total++;
        if (n != 0) begin bad++; $display("FAIL b2b_frame2_thr got=%0d_wrong want=0_wrong", n); end
    endtask

    initial begin
        clear_rec();
        test_reset();
        test_uniform();
        test_addr_order();
        test_block_thr();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
